// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode enum, flag struct and flag bit positions.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SLL = 3'd5,
      OP_SRA = 3'd6,
      OP_MUL = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic overflow;
      logic carry;
      logic negative;
      logic zero;
   } alu_flags_t;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   prod
);

   localparam int unsigned SHW = $clog2(WIDTH);

   logic                 busy_q,   busy_d;
   logic [2*WIDTH-1:0]   acc_q,    acc_d;
   logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [SHW-1:0]       cnt_q,    cnt_d;
   logic [2*WIDTH-1:0]   sum_c;

   // Partial-product accumulation and next-state for the shift-add datapath
   always_comb begin
      sum_c    = acc_q + (mplier_q[0] ? mcand_q : '0);
      busy_d   = busy_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (start) begin
         busy_d   = 1'b1;
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         cnt_d    = SHW'(WIDTH - 1);
      end else if (busy_q) begin
         acc_d    = sum_c;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - SHW'(1);
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end
      end
   end

   // Datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q   <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   // done marks the last step; prod carries that step's sum so the caller can register it on the same edge
   assign busy = busy_q;
   assign done = busy_q && (cnt_q == '0);
   assign prod = sum_c;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU stage with valid/ready handshakes, status flags and a sequential multiply.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  operand_a,
   input  logic [WIDTH-1:0]  operand_b,
   input  logic [2:0]        alu_opcode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic [3:0]        flags
);

   localparam int unsigned SHW = $clog2(WIDTH);

   typedef enum logic {S_IDLE, S_MUL} state_e;

   state_e               state_q, state_d;
   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     result_q, result_d;
   alu_flags_t           flags_q, flags_d;

   alu_op_e              op;
   logic                 accept;
   logic                 mul_start, mul_busy, mul_done;
   logic [2*WIDTH-1:0]   mul_prod;
   logic                 is_sub;
   logic [WIDTH-1:0]     b_eff;
   logic [WIDTH:0]       sum;
   logic [WIDTH-1:0]     alu_res;
   logic [3:0]           alu_flg;
   logic [3:0]           mul_flg;

   assign op        = alu_op_e'(alu_opcode);
   assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !rst && !mul_busy;
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (op == OP_MUL);

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start),
      .a     (operand_a),
      .b     (operand_b),
      .busy  (mul_busy),
      .done  (mul_done),
      .prod  (mul_prod)
   );

   // Single-cycle result and flags; SUB reuses the adder as a + ~b + 1
   always_comb begin
      is_sub  = (op == OP_SUB);
      b_eff   = is_sub ? ~operand_b : operand_b;
      sum     = {1'b0, operand_a} + {1'b0, b_eff} + (WIDTH+1)'(is_sub);
      alu_res = '0;
      alu_flg = '0;
      case (op)
         OP_ADD: begin
            alu_res         = sum[WIDTH-1:0];
            alu_flg[FLAG_C] = sum[WIDTH];
            alu_flg[FLAG_V] = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                              (sum[WIDTH-1] != operand_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res         = sum[WIDTH-1:0];
            alu_flg[FLAG_C] = ~sum[WIDTH];
            alu_flg[FLAG_V] = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                              (sum[WIDTH-1] != operand_a[WIDTH-1]);
         end
         OP_AND:  alu_res = operand_a & operand_b;
         OP_OR:   alu_res = operand_a | operand_b;
         OP_XOR:  alu_res = operand_a ^ operand_b;
         OP_SLL:  alu_res = operand_a << operand_b[SHW-1:0];
         OP_SRA:  alu_res = WIDTH'($signed(operand_a) >>> operand_b[SHW-1:0]);
         default: alu_res = '0;
      endcase
      alu_flg[FLAG_Z] = (alu_res == '0);
      alu_flg[FLAG_N] = alu_res[WIDTH-1];

      mul_flg         = '0;
      mul_flg[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
      mul_flg[FLAG_N] = mul_prod[WIDTH-1];
      mul_flg[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
   end

   // IDLE/MUL control and output slot: write on accept or multiply completion, drain on out_ready
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
      if (out_ready) begin
         out_valid_d = 1'b0;
      end
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (op == OP_MUL) begin
                  state_d = S_MUL;
               end else begin
                  out_valid_d = 1'b1;
                  result_d    = alu_res;
                  flags_d     = alu_flags_t'(alu_flg);
               end
            end
         end
         S_MUL: begin
            if (mul_done) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b1;
               result_d    = mul_prod[WIDTH-1:0];
               flags_d     = alu_flags_t'(mul_flg);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed cases, then randomized traffic against a behavioural model.
module tb_alu_pipe;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                          XOR_ = 3'd4, SLL = 3'd5, SRA = 3'd6, MUL = 3'd7;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] operand_a, operand_b;
   logic [2:0]  alu_opcode;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic [3:0]  flags;

   int n_vec = 0;
   int n_bad = 0;
   int rdy_mode = 2;           // 0 random, 1 hold low, 2 hold high
   logic [35:0] exp_q[$];      // {flags, result}

   alu_pipe #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .operand_a(operand_a), .operand_b(operand_b), .alu_opcode(alu_opcode),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: true arithmetic on wide integers, flags derived from the mathematical result
   function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic [63:0] p;
      longint      sa, sb, sr;
      logic        c, v;
      int          sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b[4:0]);
      c = 1'b0; v = 1'b0; sr = 0; p = '0;
      case (op)
         ADD: begin
            p = 64'(a) + 64'(b); r = p[31:0]; c = p[32];
            sr = sa + sb; v = (sr != longint'($signed(r)));
         end
         SUB: begin
            r = a - b; c = (a < b);
            sr = sa - sb; v = (sr != longint'($signed(r)));
         end
         AND_: r = a & b;
         OR_:  r = a | b;
         XOR_: r = a ^ b;
         SLL:  begin p = 64'(a) << sh; r = p[31:0]; end
         SRA:  r = 32'(sa >>> sh);
         default: begin
            p = 64'(a) * 64'(b); r = p[31:0]; c = (p[63:32] != 0);
         end
      endcase
      return {v, c, r[31], (r == 0), r};
   endfunction

   // Present an op and wait for its acceptance; expectation pushed when the accept edge is certain
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [35:0] exp, input bit push_en, output int waited);
      @(negedge clk);
      in_valid = 1'b1; alu_opcode = op; operand_a = a; operand_b = b;
      waited = 0;
      #2;
      while (!in_ready && waited < 300) begin
         @(negedge clk); #2;
         waited++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(waited), 64'(0));
         in_valid = 1'b0;
      end else if (push_en) begin
         exp_q.push_back(exp);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Called right after a MUL issue: counts cycles from accept edge until out_valid
   task automatic mul_latency(input string name);
      int n = 0;
      int ir_bad = 0;
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      while (!out_valid && n < 100) begin
         if (in_ready) ir_bad++;
         n++;
         @(negedge clk); #2;
      end
      chk({name, "_latency"}, 64'(n), 64'(32));
      chk({name, "_in_ready_low"}, 64'(ir_bad), 64'(0));
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: owns out_ready, pops and compares on every output handshake
   initial begin
      logic [35:0] e;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0: out_ready = ($urandom_range(0, 3) != 0);
            1: out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
         if (rst !== 1'b1 && out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 64'(result), 64'hDEAD_0000_0000_0000);
            end else begin
               e = exp_q.pop_front();
               chk("result", 64'(result), 64'(e[31:0]));
               chk("flags", 64'(flags), 64'(e[35:32]));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int n;
      rst = 1'b1; in_valid = 1'b0; alu_opcode = '0; operand_a = '0; operand_b = '0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_flags", 64'(flags), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      rst = 1'b0;

      // Directed arithmetic
      issue(ADD, 32'hAAAA_AABB, 32'h1122_3344, {4'b0010, 32'hBBCC_DDFF}, 1, w);
      issue(SUB, 32'h1122_3344, 32'hAAAA_AABB, {4'b0100, 32'h6677_8889}, 1, w);
      issue(ADD, 32'h7FFF_FFFF, 32'h0000_0001, {4'b1010, 32'h8000_0000}, 1, w);
      issue(SUB, 32'h1234_5678, 32'h1234_5678, {4'b0001, 32'h0000_0000}, 1, w);
      issue(SLL, 32'h0000_0001, 32'h0000_001F, {4'b0010, 32'h8000_0000}, 1, w);
      issue(SLL, 32'h0000_0003, 32'hFFFF_FF25, {4'b0000, 32'h0000_0060}, 1, w);
      issue(SRA, 32'h8000_0000, 32'h0000_0004, {4'b0010, 32'hF800_0000}, 1, w);

      // Back-to-back logic ops
      issue(AND_, 32'hAAAA_AAAA, 32'h5555_5555, {4'b0001, 32'h0000_0000}, 1, w);
      issue(OR_,  32'hAAAA_AAAA, 32'h5555_5555, {4'b0010, 32'hFFFF_FFFF}, 1, w);
      chk("b2b_or_stall", 64'(w), 64'(0));
      issue(XOR_, 32'hAAAA_AAAA, 32'h5555_5555, {4'b0010, 32'hFFFF_FFFF}, 1, w);
      chk("b2b_xor_stall", 64'(w), 64'(0));

      // Multiply latency and upper-half carry
      issue(MUL, 32'd7, 32'd6, {4'b0000, 32'h0000_002A}, 1, w);
      mul_latency("mul7x6");
      issue(MUL, 32'h0001_0000, 32'h0001_0000, {4'b0101, 32'h0000_0000}, 1, w);
      mul_latency("mul_big");
      idle(3);

      // Back-pressure: output held, nothing accepted
      rdy_mode = 1;
      issue(ADD, 32'd1, 32'd2, {4'b0000, 32'h0000_0003}, 1, w);
      @(negedge clk); #2;
      in_valid = 1'b1; alu_opcode = SUB; operand_a = 32'd9; operand_b = 32'd1;
      for (int k = 0; k < 5; k++) begin
         chk("hold_out_valid", 64'(out_valid), 64'(1));
         chk("hold_result", 64'(result), 64'(3));
         chk("hold_flags", 64'(flags), 64'(0));
         chk("hold_in_ready", 64'(in_ready), 64'(0));
         if (k < 4) begin
            @(negedge clk); #2;
         end
      end
      in_valid = 1'b0;
      rdy_mode = 2;
      @(negedge clk); #2;
      chk("release_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk); #2;
      chk("release_out_valid", 64'(out_valid), 64'(0));

      // Reset in the middle of a multiply
      issue(MUL, 32'h0000_1234, 32'h0000_5678, 36'h0, 0, w);
      @(negedge clk); in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #2;
      chk("midmul_rst_out_valid", 64'(out_valid), 64'(0));
      chk("midmul_rst_result", 64'(result), 64'(0));
      chk("midmul_rst_in_ready", 64'(in_ready), 64'(1));
      n = 0;
      repeat (40) begin
         @(negedge clk); #2;
         if (out_valid) n++;
      end
      chk("midmul_no_spurious", 64'(n), 64'(0));
      issue(ADD, 32'd5, 32'd5, {4'b0000, 32'h0000_000A}, 1, w);
      idle(2);

      // Randomized traffic with random back-pressure
      rdy_mode = 0;
      for (int i = 0; i < 200; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 7));
         a = rnd_val();
         b = rnd_val();
         issue(op, a, b, model(op, a, b), 1, w);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
      end

      // Drain
      rdy_mode = 2;
      idle(1);
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the combinational 3-bit-opcode ALU. Adds valid/ready handshakes on input and output, a registered result, status flags, shift operations, and a multi-cycle shift-add multiply. It sits between the operand-fetch stage and writeback, and applies back-pressure while it is busy.

Parameters:
WIDTH, 32, operand and result width in bits; must be ≥ 4 and a power of two.
SHW, $clog2(WIDTH), shift-amount width (derived; not to be overridden).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand/opcode presented
in_ready  out  1  block accepts the operation this cycle
operand_a  in  WIDTH  first operand
operand_b  in  WIDTH  second operand; shift amount is operand_b[SHW-1:0]
alu_opcode  in  3  operation select (see Behaviour)
out_valid  out  1  result and flags valid
out_ready  in  1  consumer takes the result this cycle
result  out  WIDTH  registered result
flags  out  4  {overflow, carry, negative, zero}, registered with result

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, out_valid=0, result=0, flags=0, multiply counter=0. in_ready is 0 while rst=1. Reset during a MUL abandons the MUL; no result is produced.
- Opcodes:
  - 000 ADD; 001 SUB (a-b); 010 AND; 011 OR; 100 XOR.
  - 101 SLL: a << b[SHW-1:0].
  - 110 SRA: arithmetic a >>> b[SHW-1:0].
  - 111 MUL: unsigned; low WIDTH bits of a*b.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !rst.
- An operation is accepted when in_valid && in_ready at a clk edge. Operands are captured at that edge and later operand changes are ignored.
- Single-cycle ops (000–110): result and flags are written at the accept edge, so out_valid=1 in the following cycle. Back-to-back accepts are allowed when out_ready=1, giving throughput of 1/cycle.
- MUL FSM, states IDLE and MUL:
  - Accept in IDLE → MUL. Load acc=0, mcand={WIDTH'0,a} (2*WIDTH bits), mplier=b, cnt=WIDTH-1.
  - Each MUL cycle: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1, cnt--.
  - At the edge where cnt==0, the final sum goes to the output register and the FSM returns to IDLE. out_valid rises exactly WIDTH cycles after the accept cycle.
  - The output slot is always empty at MUL completion, because in_ready required it to be free or draining at accept and no accepts occur during MUL.
- Output hold: while out_valid && !out_ready, result and flags are held stable and in_ready=0.
- Output drain: out_valid falls at the edge where out_ready=1, unless a new single-cycle op is accepted at the same edge, in which case out_valid stays 1 with the new data.
- Flags:
  - zero = (result==0); negative = result[WIDTH-1].
  - ADD: carry = carry-out of bit WIDTH-1; overflow = signed overflow.
  - SUB: carry = borrow (a<b unsigned); overflow = signed overflow of a-b.
  - AND/OR/XOR/SLL/SRA: carry=0, overflow=0.
  - MUL: carry = (upper WIDTH bits of the product != 0); overflow=0.
- Arithmetic uses a WIDTH+1-bit adder. SUB is computed as a + ~b + 1, and borrow = ~carry_out.

Decomposition:
- alu_pkg holds:
  - alu_op_e, a 3-bit enum with ADD, SUB, AND, OR, XOR, SLL, SRA, MUL.
  - alu_flags_t, a packed struct {overflow, carry, negative, zero}.
  - Flag bit-index constants.
- Sub-module alu_mul_seq (parameter WIDTH) contains the shift-add datapath and counter. Its interface is start, a, b, busy, done (1-cycle pulse), and prod[2*WIDTH-1:0]. alu_pipe owns the IDLE/MUL FSM, the handshakes and the output register.

Test Plan:
1. ADD a=AAAAAABB, b=11223344, out_ready=1 → next cycle: out_valid=1, result=BBCCDDFF, flags=0010 (neg=1).
2. SUB a=11223344, b=AAAAAABB → result=66778889, carry=1 (borrow), overflow=0. Then ADD 7FFFFFFF+00000001 → result=80000000, overflow=1, negative=1.
3. AND AAAAAAAA&55555555 → result=0, zero=1. Issue AND, OR, XOR back-to-back with out_ready=1 → three consecutive out_valid cycles with 0, FFFFFFFF, FFFFFFFF.
4. MUL 7×6 → in_ready=0 for 32 cycles, result=0000002A at exactly accept+32. Then MUL 00010000×00010000 → result=0, zero=1, carry=1.
5. Back-pressure: ADD 1+2 with out_ready=0 for 5 cycles → result=3 held stable, in_ready=0 throughout, and a new in_valid is not accepted. On out_ready=1, out_valid drops and in_ready returns to 1.
6. Reset mid-MUL: assert rst 10 cycles after MUL accept → next cycle out_valid=0, result=0, state=IDLE. No spurious out_valid afterwards, and a following ADD 5+5 → result=0000000A.
